// File: rtl/pattern_scan_ctrl.sv
// Frame-scheduled serial pattern detector: holds a programmable pattern, meters
// frame_len bits through a valid/ready handshake and counts pattern hits.
module pattern_scan_ctrl #(
  parameter int PAT_W   = 8,
  parameter int LEN_W   = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_W-1:0]   cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic               busy,
  output logic               match,
  output logic               done,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [PAT_W-1:0] DEF_PAT = PAT_W'(5'b10110);
  localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'(5);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [PAT_W-1:0]   pat_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic [PAT_W-1:0]   hist_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [FRAME_W-1:0] bit_cnt_reg;
  logic [FRAME_W-1:0] frame_len_reg;
  logic [CNT_W-1:0]   match_cnt_reg;
  logic               match_reg;
  logic               cfg_err_reg;

  logic               cfg_ok;
  logic               accept;
  logic [PAT_W-1:0]   hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_sat;
  logic [PAT_W-1:0]   pat_mask;
  logic               hit;
  logic [FRAME_W-1:0] bit_cnt_inc;
  logic               last_bit;

  assign cfg_ok      = (cfg_len != '0) && (cfg_len <= MAX_LEN);
  assign accept      = (state_reg == SCAN) && bit_valid;
  assign hist_shift  = {hist_reg[PAT_W-2:0], bit_in};
  assign fill_inc    = fill_reg + LEN_W'(1);
  assign fill_sat    = (fill_inc >= len_reg) ? len_reg : fill_inc;
  assign bit_cnt_inc = bit_cnt_reg + FRAME_W'(1);
  assign last_bit    = (bit_cnt_inc == frame_len_reg);

  // Only the low len bits of history take part in the compare.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign pat_mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  assign hit = (fill_sat == len_reg) && (((hist_shift ^ pat_reg) & pat_mask) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bit_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (frame_len == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (accept && last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg       <= DEF_PAT;
      len_reg       <= DEF_LEN;
      overlap_reg   <= 1'b1;
      hist_reg      <= '0;
      fill_reg      <= '0;
      bit_cnt_reg   <= '0;
      frame_len_reg <= '0;
      match_cnt_reg <= '0;
      match_reg     <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_we && ((state_reg != IDLE) || !cfg_ok);
      match_reg   <= accept && hit;
      if (state_reg == IDLE) begin
        // Config is loaded on the same edge as start, so the new frame sees it.
        if (cfg_we && cfg_ok) begin
          pat_reg     <= cfg_pat;
          len_reg     <= cfg_len;
          overlap_reg <= cfg_overlap;
        end
        if (start) begin
          hist_reg      <= '0;
          fill_reg      <= '0;
          bit_cnt_reg   <= '0;
          match_cnt_reg <= '0;
          frame_len_reg <= frame_len;
        end
      end
      if (accept) begin
        hist_reg    <= hist_shift;
        fill_reg    <= (hit && !overlap_reg) ? '0 : fill_sat;
        bit_cnt_reg <= bit_cnt_inc;
        if (hit && (match_cnt_reg != '1)) begin
          match_cnt_reg <= match_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign match     = match_reg;
  assign cfg_err   = cfg_err_reg;
  assign match_cnt = match_cnt_reg;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench: the driver predicts match/done/cfg_err events from a
// bit-list model of the frame; a negedge monitor pops and compares them.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       start;
  logic [7:0] frame_len;
  logic       bit_in;
  logic       bit_valid;

  logic       a_cfg_err, a_bit_ready, a_busy, a_match, a_done;
  logic [7:0] a_match_cnt;
  logic       b_cfg_err, b_bit_ready, b_busy, b_match, b_done;
  logic [1:0] b_match_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         last_raw;

  bit fbits[$];
  int match_q[$];
  int done_cnt_q[$];
  bit done_hit_q[$];
  int err_q[$];

  pattern_scan_ctrl dut_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(a_cfg_err), .start(start), .frame_len(frame_len),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(a_bit_ready), .busy(a_busy),
    .match(a_match), .done(a_done), .match_cnt(a_match_cnt)
  );

  pattern_scan_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(b_cfg_err), .start(start), .frame_len(frame_len),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(b_bit_ready), .busy(b_busy),
    .match(b_match), .done(b_done), .match_cnt(b_match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int imin(int x, int y);
    return (x < y) ? x : y;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_default();
    m_pat = 8'b0001_0110;
    m_len = 5;
    m_ovl = 1'b1;
  endtask

  task automatic set_bits(input logic [31:0] v, input int n);
    fbits.delete();
    for (int i = 0; i < n; i++) fbits.push_back(v[n-1-i]);
  endtask

  task automatic do_cfg(input logic [7:0] p, input int l, input bit o);
    cfg_we = 1'b1;
    cfg_pat = p;
    cfg_len = l[3:0];
    cfg_overlap = o;
    if (l < 1 || l > 8) err_q.push_back(1);
    else begin
      m_pat = p;
      m_len = l;
      m_ovl = o;
    end
    tick();
    cfg_we = 1'b0;
    tick();
    $display("cfg pat=%02h len=%0d ovl=%0d", p, l, o);
  endtask

  // Reference: a hit is the last len bits of the frame equalling the pattern,
  // counted only once len bits have arrived since the last non-overlap reset.
  task automatic run_frame(input int gap_pct, input bit cfg_mid);
    int n;
    int raw;
    int since;
    int gaps;
    bit hit;
    bit hist[$];
    n = fbits.size();
    raw = 0;
    since = 0;
    start = 1'b1;
    frame_len = n[7:0];
    if (n == 0) begin
      done_cnt_q.push_back(0);
      done_hit_q.push_back(1'b0);
    end
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("zero_frame_done", a_done, 1);
      tick();
      chk("zero_frame_idle", a_busy, 0);
      last_raw = 0;
      $display("frame len=0 matches=0");
      return;
    end
    for (int i = 0; i < n; i++) begin
      gaps = 0;
      while (gaps < 4 && $urandom_range(99) < gap_pct) begin
        bit_valid = 1'b0;
        bit_in = 1'($urandom);
        chk("bit_ready_gap", {a_bit_ready, b_bit_ready}, 3);
        tick();
        gaps++;
      end
      chk("bit_ready", {a_bit_ready, b_bit_ready}, 3);
      bit_valid = 1'b1;
      bit_in = fbits[i];
      if (cfg_mid && i == 2) begin
        cfg_we = 1'b1;
        cfg_pat = ~m_pat;
        cfg_len = 4'd3;
        cfg_overlap = ~m_ovl;
        err_q.push_back(1);
      end
      hist.push_back(fbits[i]);
      since++;
      hit = 1'b0;
      if (since >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (hist[hist.size()-1-k] != m_pat[k]) hit = 1'b0;
      end
      if (hit) begin
        raw++;
        match_q.push_back(raw);
        if (!m_ovl) since = 0;
      end
      if (i == n - 1) begin
        done_cnt_q.push_back(raw);
        done_hit_q.push_back(hit);
      end
      tick();
      bit_valid = 1'b0;
      cfg_we = 1'b0;
    end
    tick();
    chk("idle_after_frame", {a_busy, a_bit_ready, b_busy}, 0);
    last_raw = raw;
    $display("frame len=%0d matches=%0d", n, raw);
  endtask

  always @(negedge clk) begin
    int e;
    bit h;
    if (rst) begin
      if (a_match || b_match) begin
        if (match_q.size() == 0) chk("unexpected_match", 1, 0);
        else begin
          e = match_q.pop_front();
          chk("match_pair", {a_match, b_match}, 3);
          chk("match_cnt_a", a_match_cnt, imin(e, 255));
          chk("match_cnt_b", b_match_cnt, imin(e, 3));
        end
      end
      if (a_done || b_done) begin
        if (done_cnt_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = done_cnt_q.pop_front();
          h = done_hit_q.pop_front();
          chk("done_pair", {a_done, b_done}, 3);
          chk("done_match_coincide", {a_match, b_match}, h ? 3 : 0);
          chk("done_cnt_a", a_match_cnt, imin(e, 255));
          chk("done_cnt_b", b_match_cnt, imin(e, 3));
        end
      end
      if (a_cfg_err || b_cfg_err) begin
        if (err_q.size() == 0) chk("unexpected_cfg_err", 1, 0);
        else begin
          e = err_q.pop_front();
          chk("cfg_err_pair", {a_cfg_err, b_cfg_err}, 3);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    cfg_we = 1'b0;
    cfg_pat = '0;
    cfg_len = '0;
    cfg_overlap = 1'b0;
    start = 1'b0;
    frame_len = '0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    model_default();
    tick();
    chk("reset_outputs_a", {a_busy, a_bit_ready, a_match, a_done, a_cfg_err}, 0);
    chk("reset_outputs_b", {b_busy, b_bit_ready, b_match, b_done, b_cfg_err}, 0);
    chk("reset_cnt", a_match_cnt, 0);
    tick();
    rst = 1'b1;
    tick();

    set_bits(32'b1011010110, 10);
    run_frame(0, 1'b0);
    tick();
    chk("cnt_hold", a_match_cnt, imin(last_raw, 255));

    set_bits(32'b10110110, 8);
    run_frame(0, 1'b0);
    do_cfg(8'h16, 5, 1'b0);
    run_frame(0, 1'b0);
    do_cfg(8'h16, 5, 1'b1);

    do_cfg(8'hFF, 0, 1'b0);
    do_cfg(8'hFF, 9, 1'b0);
    set_bits(32'b1011010110, 10);
    run_frame(0, 1'b0);

    do_cfg(8'h03, 3, 1'b1);
    set_bits(32'b0110110, 7);
    run_frame(50, 1'b0);

    set_bits(32'b011011011011, 12);
    run_frame(20, 1'b1);

    fbits.delete();
    run_frame(0, 1'b0);

    // Reset mid-frame, after a config change, must restore the default pattern.
    set_bits(32'b100, 3);
    start = 1'b1;
    frame_len = 8'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in = fbits[i];
      tick();
    end
    bit_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreset_idle", {a_busy, a_bit_ready, b_busy, a_done}, 0);
    chk("midreset_cnt", a_match_cnt, 0);
    $display("reset asserted mid-frame");
    tick();
    tick();
    rst = 1'b1;
    model_default();
    tick();
    set_bits(32'b1011010110, 10);
    run_frame(0, 1'b0);

    do_cfg(8'h01, 1, 1'b1);
    set_bits(32'b111111, 6);
    run_frame(30, 1'b0);
    tick();
    chk("sat_hold_b", b_match_cnt, 3);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(9) == 0) do_cfg(8'($urandom), 0, 1'($urandom));
      do_cfg(8'($urandom), $urandom_range(1, 4), 1'($urandom));
      n = $urandom_range(1, 30);
      fbits.delete();
      for (int i = 0; i < n; i++) fbits.push_back(1'($urandom));
      run_frame(25, (n >= 3) && ($urandom_range(3) == 0));
    end

    repeat (5) tick();
    chk("match_q_drained", match_q.size(), 0);
    chk("done_q_drained", done_cnt_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
